// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Optional divide datapath is controlled by the MULDIV_DIV_EN macro.
package muldiv_pkg;

    // funct3 encodings of the M-extension operations
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int MAX_XLEN = 64;

    // Quotient returned for a divide by zero: all ones in the low xlen bits
    function automatic logic [MAX_XLEN-1:0] div_zero_quotient(input int xlen);
        return {MAX_XLEN{1'b1}} >> (MAX_XLEN - xlen);
    endfunction

    // Most-negative xlen-bit value, also the quotient of the signed overflow case
    function automatic logic [MAX_XLEN-1:0] overflow_quotient(input int xlen);
        return {{(MAX_XLEN-1){1'b0}}, 1'b1} << (xlen - 1);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational radix-2 iteration shared by multiply and divide.
// mode=0: shift-add multiply step on {high accumulator, multiplier}.
// mode=1: restoring-division step on {remainder, quotient/dividend}.
// The divide half only exists when MULDIV_DIV_EN is defined.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              mode,
    input  logic [2*XLEN-1:0] acc_in,
    input  logic [XLEN-1:0]   operand,
    output logic [2*XLEN-1:0] acc_out
);

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;

    // Multiply: add the multiplicand when the current multiplier bit is set, then shift right with carry
    always_comb begin
        mul_sum = {1'b0, acc_in[2*XLEN-1:XLEN]};
        if (acc_in[0]) begin
            mul_sum = mul_sum + {1'b0, operand};
        end
        mul_next = {mul_sum, acc_in[XLEN-1:1]};
    end

`ifdef MULDIV_DIV_EN
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] div_next;

    // Divide: bring in the next dividend bit, trial-subtract the divisor, keep it only if non-negative
    always_comb begin
        div_shift = {acc_in[2*XLEN-1:XLEN], acc_in[XLEN-1]};
        div_diff  = div_shift - {1'b0, operand};
        if (!div_diff[XLEN]) begin
            div_next = {div_diff[XLEN-1:0], acc_in[XLEN-2:0], 1'b1};
        end else begin
            div_next = {div_shift[XLEN-1:0], acc_in[XLEN-2:0], 1'b0};
        end
    end

    // Select the iteration requested by the FSM
    always_comb begin
        acc_out = mode ? div_next : mul_next;
    end
`else
    // Without a divider a divide-mode request simply holds the accumulator
    always_comb begin
        acc_out = mode ? acc_in : mul_next;
    end
`endif

endmodule

// File: rtl/muldiv_unit.sv
// Iterative M-extension execution unit: radix-2 shift-add multiply and
// restoring divide, one operation at a time, valid/ready on both sides.
// Define MULDIV_DIV_EN to build the divider; otherwise divide ops return 0.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       op_i,
    input  logic [XLEN-1:0]  a_i,
    input  logic [XLEN-1:0]  b_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [XLEN-1:0]  result_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             busy_o
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

    state_e            state;
    op_e               op_q;
    logic              neg_q;
    logic              special_q;
    logic [CNT_W-1:0]  cnt;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   operand_q;
    logic [2*XLEN-1:0] acc_next;

    op_e               op_in;
    logic              a_signed;
    logic              b_signed;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic              neg_in;
    logic              is_special;
    logic [XLEN-1:0]   special_res;

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   mul_res;
    logic [XLEN-1:0]   final_res;

    assign op_in   = op_e'(op_i);
    assign ready_o = (state == ST_IDLE);
    assign busy_o  = (state != ST_IDLE);

    muldiv_step #(.XLEN(XLEN)) u_step (
        .mode    (op_q[2]),
        .acc_in  (acc),
        .operand (operand_q),
        .acc_out (acc_next)
    );

    // Operand magnitudes and the sign the final result must carry
    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (op_in)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            OP_MULHSU: a_signed = 1'b1;
            default: ;
        endcase
        a_neg  = a_signed & a_i[XLEN-1];
        b_neg  = b_signed & b_i[XLEN-1];
        a_mag  = a_neg ? -a_i : a_i;
        b_mag  = b_neg ? -b_i : b_i;
        neg_in = (op_in == OP_REM) ? a_neg : (a_neg ^ b_neg);
    end

`ifdef MULDIV_DIV_EN
    localparam logic [XLEN-1:0] ALL_ONES = XLEN'(div_zero_quotient(XLEN));
    localparam logic [XLEN-1:0] MOST_NEG = XLEN'(overflow_quotient(XLEN));

    logic div_zero;
    logic div_ovf;
    logic [XLEN-1:0] div_sel;
    logic [XLEN-1:0] div_res;

    // Divide-by-zero and signed-overflow shortcuts, resolved at acceptance
    always_comb begin
        div_zero    = (b_i == '0);
        div_ovf     = (op_in == OP_DIV || op_in == OP_REM) && (a_i == MOST_NEG) && (b_i == '1);
        is_special  = op_i[2] && (div_zero || div_ovf);
        special_res = '0;
        if (div_zero) begin
            special_res = op_i[1] ? a_i : ALL_ONES;
        end else if (div_ovf) begin
            special_res = op_i[1] ? '0 : MOST_NEG;
        end
    end

    // Quotient or remainder of the last step, sign-corrected
    always_comb begin
        div_sel = op_q[1] ? acc_next[2*XLEN-1:XLEN] : acc_next[XLEN-1:0];
        div_res = neg_q ? -div_sel : div_sel;
    end
`else
    // Divide ops take the one-edge shortcut and return zero
    always_comb begin
        is_special  = op_i[2];
        special_res = '0;
    end
`endif

    // Sign-correct the full product, then pick the half the op asks for
    always_comb begin
        prod    = neg_q ? -acc_next : acc_next;
        mul_res = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
        final_res = op_q[2] ? div_res : mul_res;
`else
        final_res = mul_res;
`endif
    end

    // Control FSM; special cases spend one CALC edge draining the preloaded result so their latency is one edge
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= ST_IDLE;
            op_q      <= OP_MUL;
            neg_q     <= 1'b0;
            special_q <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            operand_q <= '0;
            valid_o   <= 1'b0;
            result_o  <= '0;
            tag_o     <= '0;
        end else if (flush_i) begin
            state   <= ST_IDLE;
            valid_o <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (valid_i) begin
                        op_q      <= op_in;
                        tag_o     <= tag_i;
                        neg_q     <= neg_in;
                        special_q <= is_special;
                        cnt       <= '0;
                        operand_q <= b_mag;
                        acc       <= is_special ? {{XLEN{1'b0}}, special_res}
                                                : {{XLEN{1'b0}}, a_mag};
                        state     <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (special_q) begin
                        result_o <= acc[XLEN-1:0];
                        valid_o  <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        acc <= acc_next;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == LAST_STEP) begin
                            result_o <= final_res;
                            valid_o  <= 1'b1;
                            state    <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=32): directed test-plan cases,
// random operations against an arithmetic reference model, flush and reset aborts.
// Divide expectations follow MULDIV_DIV_EN the same way the design does.
module tb_muldiv_unit;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    logic             clk_i   = 1'b0;
    logic             rst_i   = 1'b0;
    logic             flush_i = 1'b0;
    logic             valid_i = 1'b0;
    logic             ready_i = 1'b0;
    logic [2:0]       op_i    = '0;
    logic [XLEN-1:0]  a_i     = '0;
    logic [XLEN-1:0]  b_i     = '0;
    logic [TAG_W-1:0] tag_i   = '0;
    logic             ready_o;
    logic             valid_o;
    logic             busy_o;
    logic [XLEN-1:0]  result_o;
    logic [TAG_W-1:0] tag_o;

    int errors = 0;
    int checks = 0;

    muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .flush_i  (flush_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .tag_i    (tag_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .result_o (result_o),
        .tag_o    (tag_o),
        .busy_o   (busy_o)
    );

    // 100 MHz clock
    always #5 clk_i = ~clk_i;

    // Reference result straight from the M-extension arithmetic rules
    function automatic logic [31:0] refResult(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        p  = '0;
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            default: begin
`ifdef MULDIV_DIV_EN
                if (b == 32'd0) return (op[1] == 1'b0) ? 32'hFFFF_FFFF : a;
                if (op[0] == 1'b0 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return (op[1] == 1'b0) ? 32'h8000_0000 : 32'd0;
                case (op)
                    3'd4:    p = sa / sb;
                    3'd5:    p = ua / ub;
                    3'd6:    p = sa % sb;
                    default: p = ua % ub;
                endcase
                return p[31:0];
`else
                return 32'd0;
`endif
            end
        endcase
    endfunction

    // Edges from acceptance until valid_o rises
    function automatic int refLatency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!op[2]) return XLEN;
`ifdef MULDIV_DIV_EN
        if (b == 32'd0) return 1;
        if (op[0] == 1'b0 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return XLEN;
`else
        return 1;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
        end
    endtask

    // Wait for the unit to be idle, present one operation and return just after the accepting edge
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
        int w;
        w = 0;
        @(negedge clk_i);
        while (!ready_o && w < 100) begin
            @(negedge clk_i);
            w++;
        end
        checkOutput("ready_before_accept", ready_o, 1);
        op_i    = op;
        a_i     = a;
        b_i     = b;
        tag_i   = tag;
        valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
    endtask

    // Full transaction: accept, measure latency, optional back-pressure and busy-time valid_i pulses, handshake out
    task automatic runOp(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input int hold, input bit pulse);
        int          n;
        int          lat;
        logic [31:0] exp;
        exp = refResult(op, a, b);
        lat = refLatency(op, a, b);
        applyStimulus(op, a, b, tag);
        checkOutput({name, "_busy"}, {busy_o, ready_o}, 2'b10);
        n = 0;
        while (n < 100) begin
            @(posedge clk_i);
            #1;
            n++;
            if (valid_o) break;
            if (pulse) begin
                @(negedge clk_i);
                valid_i = $urandom_range(0, 1);
                op_i    = 3'($urandom);
                a_i     = $urandom;
                b_i     = $urandom;
                tag_i   = 5'($urandom);
            end
        end
        valid_i = 1'b0;
        checkOutput({name, "_latency"}, n, lat);
        checkOutput({name, "_result"}, result_o, exp);
        checkOutput({name, "_tag"}, tag_o, tag);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk_i);
            #1;
            checkOutput({name, "_hold"}, {valid_o, ready_o, tag_o, result_o}, {1'b1, 1'b0, tag, exp});
        end
        @(negedge clk_i);
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        ready_i = 1'b0;
        checkOutput({name, "_release"}, {valid_o, ready_o, busy_o}, 3'b010);
    endtask

    initial begin
        logic [2:0]  r_op;
        logic [31:0] r_a;
        logic [31:0] r_b;
        bit          seen_valid;

        $display("[TB] muldiv_unit bench start");

        // Reset state
        #2;
        checkOutput("reset_outputs", {valid_o, busy_o, tag_o, result_o}, '0);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        checkOutput("reset_ready", ready_o, 1);

        // Multiply cases
        runOp("mul_7_m3", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd17, 0, 0);
        runOp("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 0, 0);
        runOp("mulh_minneg", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd9, 0, 0);
        runOp("mulhsu_neg", 3'd2, 32'hFFFF_FFF0, 32'h1234_5678, 5'd1, 0, 0);

        // Divide cases, normal and special
        runOp("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 0, 0);
        runOp("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd5, 0, 0);
        runOp("divu_100_7", 3'd5, 32'd100, 32'd7, 5'd6, 0, 0);
        runOp("remu_100_7", 3'd7, 32'd100, 32'd7, 5'd7, 0, 0);
        runOp("divu_by0", 3'd5, 32'd5, 32'd0, 5'd8, 0, 0);
        runOp("rem_by0", 3'd6, 32'd5, 32'd0, 5'd10, 0, 0);
        runOp("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0, 0);
        runOp("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0, 0);

        // Back-pressure in DONE and valid_i pulses while calculating
        runOp("backpressure", 3'd0, 32'h0001_2345, 32'h0000_0ABC, 5'd21, 5, 0);
        runOp("busy_pulses", 3'd1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 5'd22, 0, 1);

        // Random operations against the reference model
        for (int k = 0; k < 12; k++) begin
            r_op = 3'($urandom);
            r_a  = $urandom;
            r_b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            runOp("random", r_op, r_a, r_b, 5'($urandom), 0, 0);
        end

        // Flush at CALC step 10: back to IDLE on the next edge, no result ever appears
        applyStimulus(3'd0, 32'd123, 32'd456, 5'd13);
        repeat (10) @(posedge clk_i);
        @(negedge clk_i);
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        checkOutput("flush_idle", {valid_o, busy_o, ready_o}, 3'b001);
        seen_valid = 1'b0;
        repeat (40) begin
            @(posedge clk_i);
            #1;
            if (valid_o) seen_valid = 1'b1;
        end
        checkOutput("flush_no_valid", seen_valid, 0);

        // Flush wins over a simultaneous acceptance
        @(negedge clk_i);
        valid_i = 1'b1;
        flush_i = 1'b1;
        op_i    = 3'd0;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        flush_i = 1'b0;
        checkOutput("flush_priority", {busy_o, ready_o}, 2'b01);

        // Asynchronous reset mid-CALC clears outputs without waiting for an edge
        applyStimulus(3'd3, 32'hFFFF_0000, 32'h0000_FFFF, 5'd30);
        repeat (15) @(posedge clk_i);
        @(negedge clk_i);
        #2;
        rst_i = 1'b0;
        #1;
        checkOutput("async_reset", {valid_o, busy_o, tag_o, result_o}, '0);
        @(negedge clk_i);
        rst_i = 1'b1;
        seen_valid = 1'b0;
        repeat (40) begin
            @(posedge clk_i);
            #1;
            if (valid_o) seen_valid = 1'b1;
        end
        checkOutput("reset_no_valid", seen_valid, 0);

        // A fresh operation after the abort completes normally
        runOp("after_abort", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd25, 0, 0);
        runOp("after_abort_div", 3'd4, 32'hFFFF_FF9C, 32'd7, 5'd26, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
